apb_gpio_bridge: RTL and testbench
==================================

# apb_gpio_bridge

APB-side initiator for the 6-pin GPIO block. It accepts single APB3 register transactions and turns writes into the GPIO's 8-bit command byte: opcode in [7:6], payload in [5:0]. It also captures the GPIO's BUS_W/BUS_WDATA report stream to serve pin-state reads. It sits between the APB interconnect and the GPIO instance, driving the GPIO's BUS_RDATA input and consuming its BUS_W/BUS_WDATA outputs.

## Interface
- TIMEOUT, 16: cycles to wait for a GPIO report before erroring a PIN read (≥2)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- psel  input  1  APB select
- penable  input  1  APB access phase
- pwrite  input  1  1 = write, 0 = read
- paddr  input  4  register address
- pwdata  input  8  write data
- prdata  output  8  read data, valid when pready=1
- pready  output  1  transfer complete
- pslverr  output  1  error response, valid when pready=1
- cmd_out  output  8  command byte to GPIO BUS_RDATA
- gpio_w  input  1  GPIO report strobe (BUS_W)
- gpio_wdata  input  8  GPIO report data (BUS_WDATA)

## Operation
- Register map:
  - 0 CTL: bit0 = PCTL, R/W
  - 1 DIR: [5:0], R/W
  - 2 PORT: [5:0], R/W
  - 3 PIN: [5:0], read-only
  - 4–15: invalid
- Opcodes:
  - 2'b00 CTL
  - 2'b01 DIR
  - 2'b10 PORT
  - 2'b11 NOP. The GPIO ignores it. cmd_out = 8'hC0 whenever no command is issuing.
- Shadow registers ctl_q, dir_q and port_q hold the last written values. They are updated in ISSUE.
- FSM states: IDLE, ISSUE, WAITPIN, DONE.
  - IDLE: on psel & penable, decode the access.
    - Valid write to 0/1/2: go to ISSUE and latch the command {op, pwdata[5:0]}. For CTL, the payload is {5'b0, pwdata[0]}.
    - Read of 0/1/2: go to DONE, with prdata = the zero-extended shadow.
    - Read of 3: clear the timeout counter and go to WAITPIN.
    - Write to 3 or any address ≥4: go to DONE with pslverr=1. No command is issued and no shadow changes.
  - ISSUE: cmd_out = latched command for exactly one cycle, then go to DONE.
  - WAITPIN: on gpio_w=1, prdata = {2'b0, gpio_wdata[5:0]}, go to DONE. Otherwise increment the counter; when it reaches TIMEOUT-1 without gpio_w, go to DONE with pslverr=1 and prdata=0.
  - DONE: pready=1 for one cycle, then go to IDLE. pslverr and prdata are held only in this cycle and are 0 otherwise.
- Accesses are serialized: a new access is accepted only in IDLE. psel dropping mid-transfer does not abort the FSM.
- Counter width is $clog2(TIMEOUT)+1. There is no wrap, because the counter saturates at exit.

## Timing
- Reset values:
  - prdata = 0, pready = 0, pslverr = 0, cmd_out = 8'hC0
  - shadows = 0, counter = 0, state IDLE
- Reset asserted mid-transfer aborts the transfer, with no pready. cmd_out returns to NOP asynchronously.
- Write latency: first ACCESS cycle (state IDLE), cmd_out valid the next cycle (ISSUE), pready in the cycle after that (DONE). Two wait states.
- CTL/DIR/PORT read and error responses: one wait state, with pready in the cycle after the first ACCESS cycle.
- PIN read:
  - pready comes one cycle after the cycle in which WAITPIN sees gpio_w.
  - A gpio_w already high in the first WAITPIN cycle is captured immediately, giving two wait states.
  - Worst case is TIMEOUT+1 wait states.
- cmd_out changes only on clk edges. It is never non-NOP for more than one consecutive cycle per write.

## Structure
- Package gpio_bridge_pkg holds:
  - opcode localparams OP_CTL, OP_DIR, OP_PORT, OP_NOP
  - address localparams A_CTL, A_DIR, A_PORT, A_PIN
  - the state enum
- One module only. The timeout counter stays inline; no sub-module is warranted.

## Test plan
- Reset, then write DIR=0x2A → one-cycle cmd_out=0x6A, then 0xC0; pready two cycles after penable; pslverr=0; a read of addr 1 returns 0x2A.
- Write CTL with pwdata=0xFF → cmd_out=0x01 for one cycle; a read of addr 0 returns 0x01.
- Read PIN, with gpio_w pulsed with gpio_wdata=0x35 three cycles into WAITPIN → prdata=0x35, pslverr=0.
- Read PIN with gpio_w held 0 → pready and pslverr=1 after TIMEOUT+1 wait states, prdata=0.
- Write to addr 3 and to addr 9 → pslverr=1 after one wait state; cmd_out stays 0xC0; shadows are unchanged.
- Assert rst during the ISSUE cycle of a PORT write → cmd_out=0xC0 immediately; no pready; a read of PORT after reset returns 0.

Source files
------------

// File: rtl/gpio_bridge_pkg.sv
// -----------------------------------------------------------------------------
// gpio_bridge_pkg
// Shared definitions for the APB-to-GPIO command bridge:
//   - GPIO command opcodes (bits [7:6] of the command byte)
//   - APB register addresses
//   - bridge FSM state encoding
//   - helper to assemble a command byte
// -----------------------------------------------------------------------------
package gpio_bridge_pkg;

  // Command opcodes understood by the GPIO block.
  localparam logic [1:0] OP_CTL  = 2'b00;
  localparam logic [1:0] OP_DIR  = 2'b01;
  localparam logic [1:0] OP_PORT = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  // APB register map. Anything above A_PIN is invalid.
  localparam logic [3:0] A_CTL  = 4'd0;
  localparam logic [3:0] A_DIR  = 4'd1;
  localparam logic [3:0] A_PORT = 4'd2;
  localparam logic [3:0] A_PIN  = 4'd3;

  // Idle value of the command bus; the GPIO ignores the NOP opcode.
  localparam logic [7:0] CMD_NOP = {OP_NOP, 6'b00_0000};

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAITPIN,
    DONE
  } state_t;

  // Build the GPIO command byte: opcode on top, 6-bit payload below.
  function automatic logic [7:0] make_cmd(input logic [1:0] op,
                                          input logic [5:0] payload);
    return {op, payload};
  endfunction

endpackage : gpio_bridge_pkg

// File: rtl/apb_gpio_bridge.sv
// -----------------------------------------------------------------------------
// apb_gpio_bridge
// APB3 target that turns single register writes into one-cycle GPIO command
// bytes and serves pin-state reads from the GPIO report stream.
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   psel, penable     APB select / access phase
//   pwrite            1 = write, 0 = read
//   paddr[3:0]        register address (0 CTL, 1 DIR, 2 PORT, 3 PIN)
//   pwdata[7:0]       write data
//   prdata[7:0]       read data, non-zero only while pready=1
//   pready            transfer complete (one cycle, in DONE)
//   pslverr           error response, only while pready=1
//   cmd_out[7:0]      command byte to the GPIO BUS_RDATA input (NOP = 8'hC0)
//   gpio_w            GPIO report strobe (BUS_W)
//   gpio_wdata[7:0]   GPIO report data (BUS_WDATA), pin state in [5:0]
//
// Parameter:
//   TIMEOUT           WAITPIN cycles allowed before a PIN read errors (>= 2)
// -----------------------------------------------------------------------------
module apb_gpio_bridge
  import gpio_bridge_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [3:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [7:0] cmd_out,
  input  logic       gpio_w,
  input  logic [7:0] gpio_wdata
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  // Last counter value seen in WAITPIN before giving up; the FSM leaves
  // WAITPIN on this value, so the counter never needs to wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [7:0]       r_cmd;
  logic [7:0]       r_prdata;
  logic             r_pslverr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ctl_q;
  logic [5:0]       r_dir_q;
  logic [5:0]       r_port_q;

  state_t           w_state_nxt;
  logic [7:0]       w_cmd_nxt;
  logic [7:0]       w_prdata_nxt;
  logic             w_pslverr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ctl_nxt;
  logic [5:0]       w_dir_nxt;
  logic [5:0]       w_port_nxt;
  logic             w_access;

  // Upper data bits carry no meaning for this bridge.
  logic [3:0]       w_unused_bits;
  assign w_unused_bits = {pwdata[7:6], gpio_wdata[7:6]};

  assign w_access = psel & penable;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_nxt     = CMD_NOP;   // command bus idles at NOP except in ISSUE
    w_prdata_nxt  = 8'h00;     // response fields are zero outside DONE
    w_pslverr_nxt = 1'b0;
    w_cnt_nxt     = r_cnt;
    w_ctl_nxt     = r_ctl_q;
    w_dir_nxt     = r_dir_q;
    w_port_nxt    = r_port_q;

    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (pwrite) begin
            case (paddr)
              A_CTL: begin
                w_state_nxt = ISSUE;
                w_cmd_nxt   = make_cmd(OP_CTL, {5'b0_0000, pwdata[0]});
              end
              A_DIR: begin
                w_state_nxt = ISSUE;
                w_cmd_nxt   = make_cmd(OP_DIR, pwdata[5:0]);
              end
              A_PORT: begin
                w_state_nxt = ISSUE;
                w_cmd_nxt   = make_cmd(OP_PORT, pwdata[5:0]);
              end
              default: begin
                // PIN is read-only and 4..15 are unmapped: error, no command.
                w_state_nxt   = DONE;
                w_pslverr_nxt = 1'b1;
              end
            endcase
          end else begin
            case (paddr)
              A_CTL: begin
                w_state_nxt  = DONE;
                w_prdata_nxt = {7'b000_0000, r_ctl_q};
              end
              A_DIR: begin
                w_state_nxt  = DONE;
                w_prdata_nxt = {2'b00, r_dir_q};
              end
              A_PORT: begin
                w_state_nxt  = DONE;
                w_prdata_nxt = {2'b00, r_port_q};
              end
              A_PIN: begin
                w_state_nxt = WAITPIN;
                w_cnt_nxt   = '0;
              end
              default: begin
                w_state_nxt   = DONE;
                w_pslverr_nxt = 1'b1;
              end
            endcase
          end
        end
      end

      ISSUE: begin
        // The command is on cmd_out this cycle; commit the matching shadow
        // so a reset during ISSUE leaves the shadows untouched.
        w_state_nxt = DONE;
        case (r_cmd[7:6])
          OP_CTL:  w_ctl_nxt  = r_cmd[0];
          OP_DIR:  w_dir_nxt  = r_cmd[5:0];
          OP_PORT: w_port_nxt = r_cmd[5:0];
          default: ;
        endcase
      end

      WAITPIN: begin
        if (gpio_w) begin
          w_state_nxt  = DONE;
          w_prdata_nxt = {2'b00, gpio_wdata[5:0]};
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = DONE;
          w_pslverr_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cmd     <= CMD_NOP;
      r_prdata  <= 8'h00;
      r_pslverr <= 1'b0;
      r_cnt     <= '0;
      r_ctl_q   <= 1'b0;
      r_dir_q   <= 6'h00;
      r_port_q  <= 6'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd     <= w_cmd_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ctl_q   <= w_ctl_nxt;
      r_dir_q   <= w_dir_nxt;
      r_port_q  <= w_port_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all registered or decoded from the state register, so nothing
  // here depends combinationally on APB or GPIO inputs.
  // ---------------------------------------------------------------------------
  assign prdata  = r_prdata;
  assign pready  = (r_state == DONE);
  assign pslverr = r_pslverr;
  assign cmd_out = r_cmd;

endmodule : apb_gpio_bridge

// File: tb/tb_apb_gpio_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_gpio_bridge
// Directed bench for apb_gpio_bridge. Inputs change on the falling edge and
// outputs are sampled 1 time unit after the falling edge, well clear of the
// rising edge the DUT uses.
// -----------------------------------------------------------------------------
module tb_apb_gpio_bridge;

  localparam int TIMEOUT = 16;
  localparam logic [7:0] NOP = 8'hC0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [3:0] paddr = 4'h0;
  logic [7:0] pwdata = 8'h00;
  logic       gpio_w = 1'b0;
  logic [7:0] gpio_wdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;
  logic [7:0] cmd_out;

  apb_gpio_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .cmd_out    (cmd_out),
    .gpio_w     (gpio_w),
    .gpio_wdata (gpio_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Results of the most recent transfer.
  logic [7:0] t_rdata;
  logic       t_err;
  int         t_waits;
  logic [7:0] t_cmd;
  int         t_cmd_cycles;
  logic [7:0] t_after_prdata;
  logic       t_after_pready;
  logic       t_after_err;
  logic [7:0] t_after_cmd;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One APB transfer. Wait states = ACCESS cycles sampled with pready low.
  task automatic apb(input logic wr, input logic [3:0] addr,
                     input logic [7:0] data);
    int guard;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    t_waits = 0; t_cmd = NOP; t_cmd_cycles = 0; guard = 0;
    #1;
    while (pready !== 1'b1 && guard < 64) begin
      if (cmd_out !== NOP) begin t_cmd = cmd_out; t_cmd_cycles++; end
      t_waits++;
      guard++;
      @(negedge clk);
      #1;
    end
    if (guard >= 64) check("apb_pready_timeout", 32'(pready), 32'd1);
    if (cmd_out !== NOP) begin t_cmd = cmd_out; t_cmd_cycles++; end
    t_rdata = prdata;
    t_err   = pslverr;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    #1;
    t_after_prdata = prdata;
    t_after_pready = pready;
    t_after_err    = pslverr;
    t_after_cmd    = cmd_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset values ----------------
    #12;
    check("rst_prdata",  32'(prdata),  32'h00);
    check("rst_pready",  32'(pready),  32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_cmd_out", 32'(cmd_out), 32'hC0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- DIR write 0x2A ----------------
    apb(1'b1, 4'd1, 8'h2A);
    check("dir_wr_cmd",        32'(t_cmd),          32'h6A);
    check("dir_wr_cmd_cycles", 32'(t_cmd_cycles),   32'd1);
    check("dir_wr_waits",      32'(t_waits),        32'd2);
    check("dir_wr_err",        32'(t_err),          32'h0);
    check("dir_wr_after_cmd",  32'(t_after_cmd),    32'hC0);
    check("dir_wr_after_rdy",  32'(t_after_pready), 32'h0);

    apb(1'b0, 4'd1, 8'h00);
    check("dir_rd_data",        32'(t_rdata),        32'h2A);
    check("dir_rd_waits",       32'(t_waits),        32'd1);
    check("dir_rd_err",         32'(t_err),          32'h0);
    check("dir_rd_after_data",  32'(t_after_prdata), 32'h00);

    // ---------------- CTL write 0xFF ----------------
    apb(1'b1, 4'd0, 8'hFF);
    check("ctl_wr_cmd",        32'(t_cmd),        32'h01);
    check("ctl_wr_cmd_cycles", 32'(t_cmd_cycles), 32'd1);
    check("ctl_wr_waits",      32'(t_waits),      32'd2);
    apb(1'b0, 4'd0, 8'h00);
    check("ctl_rd_data", 32'(t_rdata), 32'h01);

    // ---------------- PORT write 0x3C (upper bits dropped) ----------------
    apb(1'b1, 4'd2, 8'hFC);
    check("port_wr_cmd", 32'(t_cmd), 32'hBC);
    apb(1'b0, 4'd2, 8'h00);
    check("port_rd_data", 32'(t_rdata), 32'h3C);

    // ---------------- PIN read, report in third WAITPIN cycle ----------------
    fork
      apb(1'b0, 4'd3, 8'h00);
      begin
        repeat (5) @(negedge clk);
        gpio_w = 1'b1; gpio_wdata = 8'h35;
        @(negedge clk);
        gpio_w = 1'b0; gpio_wdata = 8'h00;
      end
    join
    check("pin_rd_data",       32'(t_rdata),        32'h35);
    check("pin_rd_err",        32'(t_err),          32'h0);
    check("pin_rd_waits",      32'(t_waits),        32'd4);
    check("pin_rd_after_data", 32'(t_after_prdata), 32'h00);

    // ---------------- PIN read, report already high ----------------
    gpio_w = 1'b1; gpio_wdata = 8'hEA;
    apb(1'b0, 4'd3, 8'h00);
    gpio_w = 1'b0; gpio_wdata = 8'h00;
    check("pin_fast_data",  32'(t_rdata), 32'h2A);
    check("pin_fast_waits", 32'(t_waits), 32'd2);

    // ---------------- PIN read timeout ----------------
    apb(1'b0, 4'd3, 8'h00);
    check("pin_to_err",       32'(t_err),       32'h1);
    check("pin_to_data",      32'(t_rdata),     32'h00);
    check("pin_to_waits",     32'(t_waits),     32'(TIMEOUT + 1));
    check("pin_to_after_err", 32'(t_after_err), 32'h0);

    // ---------------- error responses ----------------
    apb(1'b1, 4'd3, 8'h11);
    check("wr3_err",        32'(t_err),        32'h1);
    check("wr3_waits",      32'(t_waits),      32'd1);
    check("wr3_cmd_cycles", 32'(t_cmd_cycles), 32'd0);
    apb(1'b1, 4'd9, 8'h3F);
    check("wr9_err",        32'(t_err),        32'h1);
    check("wr9_waits",      32'(t_waits),      32'd1);
    check("wr9_cmd_cycles", 32'(t_cmd_cycles), 32'd0);
    check("wr9_after_cmd",  32'(t_after_cmd),  32'hC0);
    apb(1'b0, 4'd12, 8'h00);
    check("rd12_err",   32'(t_err),   32'h1);
    check("rd12_data",  32'(t_rdata), 32'h00);
    apb(1'b0, 4'd1, 8'h00);
    check("dir_kept",  32'(t_rdata), 32'h2A);
    apb(1'b0, 4'd0, 8'h00);
    check("ctl_kept",  32'(t_rdata), 32'h01);
    apb(1'b0, 4'd2, 8'h00);
    check("port_kept", 32'(t_rdata), 32'h3C);

    // ---------------- reset during ISSUE of a PORT write ----------------
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'h15;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    #1;
    check("rst_issue_cmd",   32'(cmd_out), 32'h95);
    check("rst_issue_ready", 32'(pready),  32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_cmd",   32'(cmd_out), 32'hC0);
    check("rst_async_ready", 32'(pready),  32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_hold_ready", 32'(pready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_post_ready", 32'(pready),  32'h0);
    check("rst_post_cmd",   32'(cmd_out), 32'hC0);
    apb(1'b0, 4'd2, 8'h00);
    check("rst_port_rd", 32'(t_rdata), 32'h00);
    check("rst_port_err", 32'(t_err),  32'h0);
    apb(1'b0, 4'd1, 8'h00);
    check("rst_dir_rd",  32'(t_rdata), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_apb_gpio_bridge
